// File: rtl/exc_pkg.sv
// Shared types for the exception sequencer (state encoding, cause codes, EPC offset).
// The RET state exists only when EXC_RFE_EN is defined.
package exc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
`ifdef EXC_RFE_EN
    DONE,
    RET
`else
    DONE
`endif
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_OPCODE = 2'd0,
    CAUSE_OVF    = 2'd1,
    CAUSE_DIV0   = 2'd2
  } cause_t;

  localparam logic [31:0] EPC_OFFSET = 32'd4;

endpackage

// File: rtl/exc_sequencer.sv
// Exception sequencer: latches cause/EPC, reads the handler byte from the vector
// table and loads it into PC. Optional return-from-exception path under EXC_RFE_EN.
module exc_sequencer
  import exc_pkg::*;
#(
  parameter logic [31:0] VEC_BASE = 32'd253,
  parameter int          MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        opcode_req,
  input  logic        ovf_req,
  input  logic        div0_req,
`ifdef EXC_RFE_EN
  input  logic        rfe_req,
`endif
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic        mem_sel,
  output logic [31:0] pc_next,
  output logic        pc_load,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        done,
  output logic        dbl_fault
);

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic [31:0] epc_q;
  logic [1:0]  cause_q;
  logic        dbl_q;
  logic        exc_req, accept;
  cause_t      cause_sel;
  logic        unused_mem_hi;

  assign exc_req       = opcode_req | ovf_req | div0_req;
  assign unused_mem_hi = ^mem_data[31:8];

  // Fixed priority: opcode > overflow > div0; losers are simply dropped.
  always_comb begin
    cause_sel = CAUSE_DIV0;
    if (opcode_req)   cause_sel = CAUSE_OPCODE;
    else if (ovf_req) cause_sel = CAUSE_OVF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      epc_q   <= 32'd0;
      cause_q <= 2'd0;
      dbl_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        epc_q   <= pc_in - EPC_OFFSET;
        cause_q <= cause_sel;
      end
      if (busy && exc_req) dbl_q <= 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    accept   = 1'b0;
    mem_sel  = 1'b0;
    mem_addr = 32'd0;
    pc_next  = 32'd0;
    pc_load  = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (exc_req) begin
          accept  = 1'b1;
          cnt_n   = LAT_M1;
          state_n = FETCH;
        end
`ifdef EXC_RFE_EN
        else if (rfe_req) state_n = RET;
`endif
      end
      FETCH: begin
        mem_sel  = 1'b1;
        mem_addr = VEC_BASE + {30'd0, cause_q};
        if (cnt == 2'd0) state_n = LOAD;
        else             cnt_n   = cnt - 2'd1;
      end
      LOAD: begin
        mem_sel  = 1'b1;
        mem_addr = VEC_BASE + {30'd0, cause_q};
        pc_next  = {24'd0, mem_data[7:0]};
        pc_load  = 1'b1;
        state_n  = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
`ifdef EXC_RFE_EN
      RET: begin
        pc_next = epc_q;
        pc_load = 1'b1;
        state_n = DONE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign epc       = epc_q;
  assign cause     = cause_q;
  assign dbl_fault = dbl_q;

endmodule
